pipe_adder_rca: RTL and testbench

Parametrised, pipelined ripple-carry adder/subtractor for the sky130_rhbd datapath. It is built from FA/HA-cell slices with registered carries between slices. It is the multi-bit, clocked successor to the single-bit FA/HA cells. A WIDTH-bit operation is split into STAGES equal slices, one slice per pipeline stage, and a valid/ready handshake on each side supports back-pressure.

---
 rtl/pipe_adder_rca.sv | 118 +++++++++++
 tb/tb_pipe_adder_rca.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_adder_rca.sv
// rtl/pipe_adder_rca.sv - pipelined ripple-carry adder/subtractor with valid/ready flow control
module pipe_adder_rca #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int W_S  = WIDTH / STAGES;
    localparam int LAST = STAGES - 1;

    // Stage registers: valid bit, skewed operands, partial sum and slice carry-out
    logic [STAGES-1:0] vld_q;
    logic [STAGES-1:0] c_q;
    logic [WIDTH-1:0]  a_q [STAGES];
    logic [WIDTH-1:0]  b_q [STAGES];
    logic [WIDTH-1:0]  s_q [STAGES];
    // Carry into the MSB, only needed by the last stage for signed overflow
    logic              cm_q;

    // Per-stage inputs and ripple results
    logic [WIDTH-1:0]  a_src [STAGES];
    logic [WIDTH-1:0]  b_src [STAGES];
    logic [WIDTH-1:0]  s_src [STAGES];
    logic [STAGES-1:0] c_src;
    logic [WIDTH-1:0]  s_d [STAGES];
    logic [STAGES-1:0] c_d;
    logic              cm_d;
    logic              advance;

    // The whole pipe moves together unless the output holds a result nobody takes
    assign advance   = !vld_q[LAST] || out_ready;
    assign in_ready  = advance;
    assign out_valid = vld_q[LAST];
    assign sum       = s_q[LAST];
    assign cout      = c_q[LAST];
    assign ovf       = c_q[LAST] ^ cm_q;

    // Route stage inputs: stage 0 gets the prepared beat, later stages the previous register
    always_comb begin
        c_src    = '0;
        a_src[0] = a;
        b_src[0] = mode ? ~b : b;
        s_src[0] = '0;
        c_src[0] = mode ? 1'b1 : cin;
        for (int k = 1; k < STAGES; k++) begin
            a_src[k] = a_q[k-1];
            b_src[k] = b_q[k-1];
            s_src[k] = s_q[k-1];
            c_src[k] = c_q[k-1];
        end
    end

    // One full-adder per bit, rippling across slice k only; lower sum bits pass through
    always_comb begin
        logic rc;
        logic ai;
        logic bi;
        rc   = 1'b0;
        ai   = 1'b0;
        bi   = 1'b0;
        cm_d = 1'b0;
        c_d  = '0;
        for (int k = 0; k < STAGES; k++) begin
            s_d[k] = s_src[k];
            rc     = c_src[k];
            for (int j = 0; j < W_S; j++) begin
                ai = a_src[k][k*W_S + j];
                bi = b_src[k][k*W_S + j];
                if (k == LAST && j == W_S - 1) begin
                    cm_d = rc;
                end
                s_d[k][k*W_S + j] = ai ^ bi ^ rc;
                rc = (ai & bi) | (rc & (ai ^ bi));
            end
            c_d[k] = rc;
        end
    end

    // Pipeline registers: clear on reset, hold everything while stalled, shift otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            c_q   <= '0;
            cm_q  <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
        end else if (advance) begin
            vld_q[0] <= in_valid;
            for (int k = 1; k < STAGES; k++) begin
                vld_q[k] <= vld_q[k-1];
            end
            c_q  <= c_d;
            cm_q <= cm_d;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= a_src[k];
                b_q[k] <= b_src[k];
                s_q[k] <= s_d[k];
            end
        end
    end

endmodule

// File: tb/tb_pipe_adder_rca.sv
// tb/tb_pipe_adder_rca.sv - self-checking bench for pipe_adder_rca
module tb_pipe_adder_rca;

    localparam int W   = 16;
    localparam int STG = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          mode = 1'b0;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          cin = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  sum;
    logic          cout;
    logic          ovf;

    int checks = 0;
    int errors = 0;

    logic [17:0] q16 [$];

    typedef struct {
        logic        m;
        logic [15:0] x;
        logic [15:0] y;
        logic        ci;
        logic [15:0] s;
        logic        co;
        logic        ov;
    } vec_t;

    vec_t vecs [12];

    always #5 clk = ~clk;

    pipe_adder_rca #(.WIDTH(W), .STAGES(STG)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .mode(mode), .a(a), .b(b), .cin(cin),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: sign-rule overflow on the prepared operands, {ovf, cout, sum}
    function automatic logic [17:0] model16(input logic m, input logic [15:0] x, input logic [15:0] y,
                                            input logic ci);
        logic [15:0] yb;
        logic [16:0] full;
        logic        ov;
        yb   = m ? ~y : y;
        full = {1'b0, x} + {1'b0, yb} + {16'd0, (m ? 1'b1 : ci)};
        ov   = (x[15] == yb[15]) && (full[15] != x[15]);
        return {ov, full[16], full[15:0]};
    endfunction

    task automatic pop_chk(input string tag);
        logic [17:0] e;
        if (q16.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s.underflow: result 0x%0h with no expected entry", tag, sum);
        end else begin
            e = q16.pop_front();
            chk({tag, ".sum"}, 64'(sum), 64'(e[15:0]));
            chk({tag, ".cout"}, 64'(cout), 64'(e[16]));
            chk({tag, ".ovf"}, 64'(ovf), 64'(e[17]));
        end
    endtask

    task automatic rand_beat();
        mode = 1'($urandom);
        a    = 16'($urandom);
        b    = 16'($urandom);
        cin  = 1'($urandom);
    endtask

    task automatic apply_vec(input vec_t v, input string tag);
        int n;
        mode = v.m; a = v.x; b = v.y; cin = v.ci;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        chk({tag, ".in_ready"}, 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        a = 16'hDEAD; b = 16'hBEEF; cin = ~v.ci; mode = ~v.m;
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, ".latency"}, 64'(n), 64'(STG - 1));
        chk({tag, ".sum"}, 64'(sum), 64'(v.s));
        chk({tag, ".cout"}, 64'(cout), 64'(v.co));
        chk({tag, ".ovf"}, 64'(ovf), 64'(v.ov));
        @(negedge clk);
        chk({tag, ".consumed"}, 64'(out_valid), 64'd0);
    endtask

    for (genvar gi = 0; gi < 3; gi++) begin : g_sw
        localparam int SW = (gi == 2) ? 32 : 8;
        localparam int SS = (gi == 0) ? 1 : ((gi == 1) ? 8 : 4);

        logic          s_in_valid = 1'b0;
        logic          s_in_ready;
        logic          s_mode = 1'b0;
        logic [SW-1:0] s_a = '0;
        logic [SW-1:0] s_b = '0;
        logic          s_cin = 1'b0;
        logic          s_out_valid;
        logic          s_out_ready = 1'b1;
        logic [SW-1:0] s_sum;
        logic          s_cout;
        logic          s_ovf;

        pipe_adder_rca #(.WIDTH(SW), .STAGES(SS)) dut (
            .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
            .mode(s_mode), .a(s_a), .b(s_b), .cin(s_cin),
            .out_valid(s_out_valid), .out_ready(s_out_ready),
            .sum(s_sum), .cout(s_cout), .ovf(s_ovf)
        );

        function automatic logic [SW+1:0] model(input logic m, input logic [SW-1:0] x,
                                                input logic [SW-1:0] y, input logic ci);
            logic [SW-1:0] yb;
            logic [SW:0]   full;
            logic          ov;
            yb   = m ? ~y : y;
            full = {1'b0, x} + {1'b0, yb} + {{SW{1'b0}}, (m ? 1'b1 : ci)};
            ov   = (x[SW-1] == yb[SW-1]) && (full[SW-1] != x[SW-1]);
            return {ov, full[SW], full[SW-1:0]};
        endfunction

        task automatic load(input int idx, input int n);
            if (idx >= n) begin
                s_in_valid = 1'b0;
            end else begin
                s_in_valid = (idx < 5) || ($urandom_range(4) != 0);
                case (idx)
                    0: begin s_mode = 1'b0; s_a = '1; s_b = SW'(1); s_cin = 1'b0; end
                    1: begin s_mode = 1'b0; s_a = {1'b0, {(SW-1){1'b1}}}; s_b = '0; s_cin = 1'b1; end
                    2: begin s_mode = 1'b1; s_a = SW'(5); s_b = SW'(7); s_cin = 1'b0; end
                    3: begin s_mode = 1'b1; s_a = {1'b1, {(SW-1){1'b0}}}; s_b = SW'(1); s_cin = 1'b0; end
                    4: begin s_mode = 1'b1; s_a = SW'(5); s_b = SW'(7); s_cin = 1'b1; end
                    default: begin
                        s_mode = 1'($urandom);
                        s_a    = SW'($urandom);
                        s_b    = SW'($urandom);
                        s_cin  = 1'($urandom);
                    end
                endcase
            end
        endtask

        task automatic run(input int nbeats);
            logic [SW+1:0] q [$];
            logic [SW+1:0] e;
            logic          took;
            int            sent;
            int            seen;
            sent = 0;
            seen = 0;
            load(0, nbeats);
            for (int t = 0; t < 8 * nbeats + 200 && seen < nbeats; t++) begin
                s_out_ready = ($urandom_range(3) != 0);
                #1;
                if (s_out_valid && s_out_ready) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL sw%0d.underflow: result 0x%0h with no expected entry", gi, s_sum);
                    end else begin
                        e = q.pop_front();
                        chk($sformatf("sw%0d.sum", gi), 64'(s_sum), 64'(e[SW-1:0]));
                        chk($sformatf("sw%0d.cout", gi), 64'(s_cout), 64'(e[SW]));
                        chk($sformatf("sw%0d.ovf", gi), 64'(s_ovf), 64'(e[SW+1]));
                    end
                    seen++;
                end
                took = s_in_valid && s_in_ready;
                if (took) begin
                    q.push_back(model(s_mode, s_a, s_b, s_cin));
                    sent++;
                end
                @(negedge clk);
                if (took || !s_in_valid) load(sent, nbeats);
            end
            s_in_valid  = 1'b0;
            s_out_ready = 1'b1;
            chk($sformatf("sw%0d.seen", gi), 64'(seen), 64'(nbeats));
            chk($sformatf("sw%0d.left", gi), 64'(q.size()), 64'd0);
        endtask
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1);
    end

    initial begin
        int          n;
        int          nv;
        int          first_v;
        int          last_v;
        int          acc;
        logic        took;
        logic [17:0] held;

        vecs[0]  = '{1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[1]  = '{1'b0, 16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1};
        vecs[2]  = '{1'b1, 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1};
        vecs[4]  = '{1'b1, 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[7]  = '{1'b1, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 16'h0FFF, 16'h0000, 1'b1, 16'h1000, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[11] = '{1'b0, 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};

        @(negedge clk);
        chk("reset.out_valid", 64'(out_valid), 64'd0);
        chk("reset.sum", 64'(sum), 64'd0);
        chk("reset.cout", 64'(cout), 64'd0);
        chk("reset.ovf", 64'(ovf), 64'd0);
        chk("reset.in_ready", 64'(in_ready), 64'd1);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            apply_vec(vecs[i], $sformatf("vec%0d", i));
        end

        q16.delete();
        out_ready = 1'b1;
        nv = 0; first_v = -1; last_v = -1;
        for (int c = 0; c < 8 + STG + 4; c++) begin
            if (c < 8) begin
                rand_beat();
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid) begin
                pop_chk("stream");
                nv++;
                if (first_v < 0) first_v = c;
                last_v = c;
            end
            if (in_valid && in_ready) q16.push_back(model16(mode, a, b, cin));
            @(negedge clk);
        end
        chk("stream.count", 64'(nv), 64'd8);
        chk("stream.contiguous", 64'(last_v - first_v), 64'd7);
        chk("stream.left", 64'(q16.size()), 64'd0);

        q16.delete();
        out_ready = 1'b0;
        rand_beat();
        in_valid = 1'b1;
        acc = 0;
        for (int t = 0; t < 20 && !out_valid; t++) begin
            #1;
            took = in_ready;
            if (took) begin
                q16.push_back(model16(mode, a, b, cin));
                acc++;
            end
            @(negedge clk);
            if (took) rand_beat();
        end
        chk("bp.accepted", 64'(acc), 64'(STG));
        held = {ovf, cout, sum};
        for (int t = 0; t < 5; t++) begin
            #1;
            chk("bp.in_ready", 64'(in_ready), 64'd0);
            chk("bp.out_valid", 64'(out_valid), 64'd1);
            chk("bp.held", 64'({ovf, cout, sum}), 64'(held));
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int t = 0; t < 20 && q16.size() > 0; t++) begin
            #1;
            if (out_valid) pop_chk("bp.drain");
            @(negedge clk);
        end
        chk("bp.left", 64'(q16.size()), 64'd0);
        #1;
        chk("bp.no_extra", 64'(out_valid), 64'd0);
        @(negedge clk);

        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            mode = 1'b0; a = 16'(16'h1111 * (i + 1)); b = 16'h0101; cin = 1'b0;
            in_valid = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("rst.pre_valid", 64'(out_valid), 64'd1);
        chk("rst.pre_sum", 64'(sum), 64'h1212);
        #2;
        rst = 1'b1;
        #1;
        chk("rst.out_valid", 64'(out_valid), 64'd0);
        chk("rst.sum", 64'(sum), 64'd0);
        chk("rst.cout", 64'(cout), 64'd0);
        chk("rst.ovf", 64'(ovf), 64'd0);
        chk("rst.in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        nv = 0;
        for (int t = 0; t < 8; t++) begin
            #1;
            if (out_valid) nv++;
            @(negedge clk);
        end
        chk("rst.stale", 64'(nv), 64'd0);
        apply_vec(vecs[8], "rst.after");

        g_sw[0].run(600);
        g_sw[1].run(600);
        g_sw[2].run(600);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
